// File: rtl/logic_pipe.sv
// logic_pipe: two-stage valid/ready pipeline applying a bitwise logic operation across
// NIN operands of WIDTH bits each.
//
// Ports:
//   clk        - single clock; all state updates on its rising edge
//   rst        - asynchronous, active-high reset
//   in_valid   - in_data/in_op hold a transaction
//   in_ready   - block accepts a transaction this cycle
//   in_data    - NIN packed operands; operand k is bits [k*WIDTH +: WIDTH]
//   in_op      - operation select: 0 AND, 1 OR, 2 NOR, 3 NAND, 4 XOR, 5 XNOR,
//                6 pass operand 0, 7 invert operand 0
//   out_valid  - out_data/out_zero/out_par hold a result
//   out_ready  - consumer accepts the result this cycle
//   out_data   - result
//   out_zero   - out_data == 0
//   out_par    - XOR reduction of out_data
//   out_count  - number of completed output handshakes (wraps)
//
// Stage S1 holds the computed result; stage S2 holds the registered result together with
// its zero and parity flags. The zero/parity flags are derived from S1 as it moves into S2
// so they stay aligned with out_data and are held stable under backpressure.

module logic_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NIN   = 2,
    parameter int unsigned CNTW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NIN*WIDTH-1:0] in_data,
    input  logic [2:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_zero,
    output logic                 out_par,
    output logic [CNTW-1:0]      out_count
);

    // Elaboration-time parameter legality checks.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("logic_pipe: WIDTH must be in 1..32");
    end
    if (NIN < 2 || NIN > 8) begin : g_bad_nin
        $error("logic_pipe: NIN must be in 2..8");
    end
    if (CNTW < 1) begin : g_bad_cntw
        $error("logic_pipe: CNTW must be at least 1");
    end

    localparam logic [2:0] OpAnd  = 3'd0;
    localparam logic [2:0] OpOr   = 3'd1;
    localparam logic [2:0] OpNor  = 3'd2;
    localparam logic [2:0] OpNand = 3'd3;
    localparam logic [2:0] OpXor  = 3'd4;
    localparam logic [2:0] OpXnor = 3'd5;
    localparam logic [2:0] OpPass = 3'd6;
    localparam logic [2:0] OpInv  = 3'd7;

    // ------------------------------------------------------------------
    // Combinational operation on the incoming operands
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] acc_and;
    logic [WIDTH-1:0] acc_or;
    logic [WIDTH-1:0] acc_xor;
    logic [WIDTH-1:0] opnd0;
    logic [WIDTH-1:0] result;

    always_comb begin
        acc_and = '1;
        acc_or  = '0;
        acc_xor = '0;
        for (int unsigned k = 0; k < NIN; k++) begin
            acc_and = acc_and & in_data[k*WIDTH +: WIDTH];
            acc_or  = acc_or  | in_data[k*WIDTH +: WIDTH];
            acc_xor = acc_xor ^ in_data[k*WIDTH +: WIDTH];
        end
        opnd0 = in_data[WIDTH-1:0];
    end

    always_comb begin
        result = '0;
        unique case (in_op)
            OpAnd:   result = acc_and;
            OpOr:    result = acc_or;
            OpNor:   result = ~acc_or;
            OpNand:  result = ~acc_and;
            OpXor:   result = acc_xor;
            OpXnor:  result = ~acc_xor;
            OpPass:  result = opnd0;
            OpInv:   result = ~opnd0;
            default: result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q,  s1_data_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q,  s2_data_d;
    logic             s2_zero_q,  s2_zero_d;
    logic             s2_par_q,   s2_par_d;
    logic [CNTW-1:0]  cnt_q,      cnt_d;

    logic s1_move;   // S1 content transfers into S2 at the next edge
    logic s1_load;   // input handshake
    logic out_fire;  // output handshake

    always_comb begin
        out_fire = s2_valid_q && out_ready;
        s1_move  = s1_valid_q && (!s2_valid_q || out_ready);
        // Combinational path from out_ready lets a full pipe accept while draining.
        in_ready = !s1_valid_q || !s2_valid_q || out_ready;
        s1_load  = in_valid && in_ready;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_data_d  = result;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_zero_d  = s2_zero_q;
        s2_par_d   = s2_par_q;
        if (s1_move) begin
            s2_valid_d = 1'b1;
            s2_data_d  = s1_data_q;
            s2_zero_d  = (s1_data_q == '0);
            s2_par_d   = ^s1_data_q;
        end else if (out_fire) begin
            // Data fields keep their last value; only the valid bit drops.
            s2_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (out_fire) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_zero_q  <= 1'b1;
            s2_par_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_zero_q  <= s2_zero_d;
            s2_par_q   <= s2_par_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_zero  = s2_zero_q;
    assign out_par   = s2_par_q;
    assign out_count = cnt_q;

endmodule

// File: tb/tb_logic_pipe.sv
// Scoreboard bench for logic_pipe. Main instance: WIDTH=8, NIN=2, CNTW=4 (small counter so
// the wrap is reachable). Second instance: WIDTH=8, NIN=4 for the multi-operand case.
// Inputs change 2 time units after a rising edge; outputs are sampled on falling edges.

module tb_logic_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_zero;
    logic        out_par;
    logic [3:0]  out_count;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [31:0] b_in_data;
    logic [2:0]  b_in_op;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [7:0]  b_out_data;
    logic        b_out_zero;
    logic        b_out_par;
    logic [15:0] b_out_count;

    always #5 clk = ~clk;

    logic_pipe #(.WIDTH(8), .NIN(2), .CNTW(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_par   (out_par),
        .out_count (out_count)
    );

    logic_pipe #(.WIDTH(8), .NIN(4), .CNTW(16)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_op     (b_in_op),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_zero  (b_out_zero),
        .out_par   (b_out_par),
        .out_count (b_out_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Expected entries packed as {data[7:0], zero, par}.
    logic [9:0] exp_q[$];
    logic [9:0] expb_q[$];
    int exp_cnt = 0;

    int cyc = 0;
    bit chk_consec = 0;
    int consec_pops = 0;
    int last_pop_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Monitor: pops the scoreboard whenever a handshake will occur at the next edge.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst) begin
            exp_cnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {24'd0, out_data}, {24'd0, e[9:2]});
                    check("out_zero", {31'd0, out_zero}, {31'd0, e[1]});
                    check("out_par", {31'd0, out_par}, {31'd0, e[0]});
                end
                check("out_count", {28'd0, out_count}, exp_cnt);
                exp_cnt = (exp_cnt + 1) % 16;
                if (chk_consec) begin
                    if (consec_pops > 0) check("consecutive", cyc, last_pop_cyc + 1);
                    last_pop_cyc = cyc;
                    consec_pops++;
                end
            end
            if (b_out_valid && b_out_ready) begin
                if (expb_q.size() == 0) begin
                    fail_now("b_unexpected_output");
                end else begin
                    e = expb_q.pop_front();
                    check("b_out_data", {24'd0, b_out_data}, {24'd0, e[9:2]});
                    check("b_out_zero", {31'd0, b_out_zero}, {31'd0, e[1]});
                    check("b_out_par", {31'd0, b_out_par}, {31'd0, e[0]});
                end
            end
        end
    end

    // Drive one transaction and wait (bounded) for its acceptance. Call at posedge+2;
    // returns at posedge+2 after the accepting edge with in_valid dropped.
    task automatic send(input logic [2:0] op, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [9:0] exp, output int waits);
        bit acc;
        acc = 0;
        waits = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = {d1, d0};
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp);
                acc = 1;
                break;
            end
            waits++;
        end
        if (!acc) fail_now("accept_timeout");
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0 && expb_q.size() == 0) break;
            @(posedge clk);
        end
        @(posedge clk);
        #2;
        if (exp_q.size() != 0 || expb_q.size() != 0) fail_now("drain");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
        check({tag, "_out_zero"}, {31'd0, out_zero}, 32'd1);
        check({tag, "_out_par"}, {31'd0, out_par}, 32'd0);
        check({tag, "_out_count"}, {28'd0, out_count}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Sweep vectors on operands 0xA5 / 0x3C, ops 0..7.
    logic [7:0] sweep_exp [8] = '{8'h24, 8'hBD, 8'h42, 8'hDB, 8'h99, 8'h66, 8'hA5, 8'h5A};

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        logic [7:0] v;
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        in_op       = '0;
        out_ready   = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_in_op     = '0;
        b_out_ready = 1'b1;

        // Asynchronous reset: asserted and checked before any clock edge.
        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Basic op on the first edge after release, latency two edges.
        send(3'd2, 8'h0F, 8'h30, {8'hC0, 1'b0, 1'b0}, w);
        check("first_accept_waits", w, 0);
        @(negedge clk);
        check("latency_stage1_only", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("latency_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #2 check("count_after_one", {28'd0, out_count}, 32'd1);
        drain();

        // Multi-operand zero result on the NIN=4 instance.
        b_in_valid = 1'b1;
        b_in_op    = 3'd0;
        b_in_data  = {8'h0F, 8'h3C, 8'hF0, 8'hFF};
        @(negedge clk);
        check("b_in_ready", {31'd0, b_in_ready}, 32'd1);
        expb_q.push_back({8'h00, 1'b1, 1'b0});
        @(posedge clk);
        #2 b_in_valid = 1'b0;
        drain();

        // Full op sweep, back-to-back, outputs on consecutive cycles.
        chk_consec  = 1;
        consec_pops = 0;
        for (int i = 0; i < 8; i++) begin
            v = sweep_exp[i];
            send(3'(i), 8'hA5, 8'h3C, {v, 1'b0, 1'b0}, w);
        end
        drain();
        chk_consec = 0;
        check("sweep_pop_count", consec_pops, 8);

        // Odd parity and zero result on the main instance.
        send(3'd4, 8'h01, 8'h00, {8'h01, 1'b0, 1'b1}, w);
        send(3'd4, 8'h55, 8'h55, {8'h00, 1'b1, 1'b0}, w);
        drain();

        // Backpressure: two accepted, third stalls while output holds.
        out_ready = 1'b0;
        send(3'd1, 8'h01, 8'h02, {8'h03, 1'b0, 1'b0}, w);
        send(3'd0, 8'h07, 8'h0E, {8'h06, 1'b0, 1'b0}, w);
        in_valid = 1'b1;
        in_op    = 3'd7;
        in_data  = {8'h00, 8'hFE};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_out_data", {24'd0, out_data}, 32'h03);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        send(3'd7, 8'hFE, 8'h00, {8'h01, 1'b0, 1'b1}, w);
        check("release_same_cycle_accept", w, 0);
        drain();

        // Reset with both stages full: nothing stale afterwards.
        out_ready = 1'b0;
        send(3'd1, 8'hF0, 8'h0F, {8'hFF, 1'b0, 1'b0}, w);
        send(3'd6, 8'h81, 8'h00, {8'h81, 1'b0, 1'b0}, w);
        @(negedge clk);
        check("prefull_out_valid", {31'd0, out_valid}, 32'd1);
        check("prefull_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midreset");
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #2;

        // Counter wrap: 17 handshakes on a 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            v = 8'(i * 13 + 1);
            send(3'd6, v, 8'h00, {v, (v == 8'h00), ^v}, w);
        end
        drain();
        check("count_wrap", {28'd0, out_count}, 32'd1);

        check("scoreboard_empty", exp_q.size() + expb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
